// File: rtl/rh_gpv_cap_pkg.sv
// Shared definitions for the general-purpose-vector capture block:
// parameter defaults, the capture state encoding and a saturating helper.
package rh_gpv_cap_pkg;

  localparam int DEF_VECTOR_WIDTH = 32;
  localparam int DEF_TS_WIDTH     = 16;
  localparam int DEF_DEPTH        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } cap_state_t;

  // Drop counter stops at 255 so a long overflow burst never wraps to a small value
  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/rh_gpv_cap_if.sv
// Valid/ready event stream carrying the captured vector and its timestamp.
interface rh_gpv_cap_if
  import rh_gpv_cap_pkg::*;
#(
  parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
  parameter int TS_WIDTH     = DEF_TS_WIDTH
);

  logic                    out_valid;
  logic                    out_ready;
  logic [VECTOR_WIDTH-1:0] out_vector;
  logic [TS_WIDTH-1:0]     out_timestamp;

  modport master (
    output out_valid,
    output out_vector,
    output out_timestamp,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_vector,
    input  out_timestamp,
    output out_ready
  );

endinterface

// File: rtl/rh_gpv_cap_fifo.sv
// Synchronous event FIFO. The head entry is presented combinationally and
// forced to zero while empty, so the outputs are clean straight out of reset.
module rh_gpv_cap_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_level;
  logic             w_full;
  logic             w_empty;
  logic             w_popOk;
  logic             w_pushOk;

  assign w_full   = (r_level == LW'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_popOk  = i_pop && !w_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_pushOk = i_push && (!w_full || w_popOk);

  // Pointers wrap naturally because DEPTH is a power of two; flush wins over everything
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_popOk)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_pushOk, w_popOk})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array needs no reset; stale contents are never shown while empty
  always_ff @(posedge clock) begin
    if (w_pushOk && !i_flush) r_mem[r_wrPtr] <= i_wdata;
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rdPtr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_level;

endmodule

// File: rtl/rh_gpv_capture.sv
// Watches a general-purpose vector for masked bit changes while running and
// queues each change with its cycle timestamp on a valid/ready stream.
module rh_gpv_capture
  import rh_gpv_cap_pkg::*;
#(
  parameter  int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
  parameter  int TS_WIDTH     = DEF_TS_WIDTH,
  parameter  int DEPTH        = DEF_DEPTH,
  localparam int LW           = $clog2(DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [VECTOR_WIDTH-1:0] vector,
  input  logic [VECTOR_WIDTH-1:0] mask,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    halt_on_full,
  rh_gpv_cap_if.master            out_if,
  output logic [1:0]              state,
  output logic                    overflow,
  output logic [7:0]              drop_count,
  output logic [LW-1:0]           level
);

  cap_state_t                       r_state;
  cap_state_t                       w_stateNext;
  logic [VECTOR_WIDTH-1:0]          r_prev;
  logic [TS_WIDTH-1:0]              r_ts;
  logic                             r_overflow;
  logic [7:0]                       r_dropCount;
  logic                             w_change;
  logic                             w_event;
  logic                             w_pop;
  logic                             w_pushOk;
  logic                             w_drop;
  logic                             w_full;
  logic                             w_empty;
  logic [LW-1:0]                    w_level;
  logic [LW-1:0]                    w_levelNext;
  logic [VECTOR_WIDTH+TS_WIDTH-1:0] w_headData;

  // Only RUN samples changes; a clear in the same cycle throws the event away
  assign w_change    = |((vector ^ r_prev) & mask);
  assign w_event     = (r_state == RUN) && w_change && !clear;
  assign w_pop       = out_if.out_ready && !w_empty;
  assign w_pushOk    = w_event && (!w_full || w_pop);
  assign w_drop      = w_event && w_full && !w_pop;
  assign w_levelNext = w_level + LW'(w_pushOk) - LW'(w_pop);

  rh_gpv_cap_fifo #(
    .WIDTH (VECTOR_WIDTH + TS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_event),
    .i_pop   (w_pop),
    .i_flush (clear),
    .i_wdata ({vector, r_ts}),
    .o_rdata (w_headData),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Previous-vector register tracks the input every cycle, whatever the state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_prev <= '0;
    else       r_prev <= vector;
  end

  // Free-running timestamp, restarted by clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      r_ts <= '0;
    else if (clear) r_ts <= '0;
    else            r_ts <= r_ts + TS_WIDTH'(1);
  end

  // Sticky overflow flag and saturating count of events that found no room
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end else if (clear) begin
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end else if (w_drop) begin
      r_overflow  <= 1'b1;
      r_dropCount <= satInc8(r_dropCount);
    end
  end

  // Capture state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Next state: clear beats everything, stop beats start, HALT as the FIFO fills
  always_comb begin
    w_stateNext = r_state;
    if (clear) begin
      w_stateNext = IDLE;
    end else begin
      case (r_state)
        IDLE: if (start && !stop) w_stateNext = RUN;
        RUN: begin
          if (stop)
            w_stateNext = IDLE;
          else if (halt_on_full && (w_levelNext == LW'(DEPTH)))
            w_stateNext = HALT;
        end
        HALT:    if (stop) w_stateNext = IDLE;
        default: w_stateNext = IDLE;
      endcase
    end
  end

  assign out_if.out_valid     = !w_empty;
  assign out_if.out_vector    = w_headData[VECTOR_WIDTH+TS_WIDTH-1:TS_WIDTH];
  assign out_if.out_timestamp = w_headData[TS_WIDTH-1:0];

  assign state      = r_state;
  assign overflow   = r_overflow;
  assign drop_count = r_dropCount;
  assign level      = w_level;

endmodule

// File: tb/tb_rh_gpv_capture.sv
// Directed scenarios followed by a random run, all checked against a
// queue-based model of the capture rules.
module tb_rh_gpv_capture;

  localparam int VW    = 8;
  localparam int TSW   = 4;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [VW-1:0] vector;
  logic [VW-1:0] mask;
  logic          start;
  logic          stop;
  logic          clear;
  logic          halt_on_full;
  logic [1:0]    state;
  logic          overflow;
  logic [7:0]    drop_count;
  logic [LW-1:0] level;

  rh_gpv_cap_if #(.VECTOR_WIDTH(VW), .TS_WIDTH(TSW)) capIf ();

  rh_gpv_capture #(
    .VECTOR_WIDTH (VW),
    .TS_WIDTH     (TSW),
    .DEPTH        (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .vector       (vector),
    .mask         (mask),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .halt_on_full (halt_on_full),
    .out_if       (capIf),
    .state        (state),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .level        (level)
  );

  always #5 clock = ~clock;

  int testCount = 0;
  int failCount = 0;

  // Reference model: queue of captured entries plus bookkeeping
  logic [VW-1:0]  mQVec[$];
  logic [TSW-1:0] mQTs[$];
  int             mState;
  logic [VW-1:0]  mPrev;
  int             mTs;
  bit             mOverflow;
  int             mDrop;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    mQVec.delete();
    mQTs.delete();
    mState    = 0;
    mPrev     = '0;
    mTs       = 0;
    mOverflow = 1'b0;
    mDrop     = 0;
  endtask

  task automatic modelStep();
    bit pop;
    bit evt;
    pop = (mQVec.size() != 0) && capIf.out_ready;
    evt = (mState == 1) && (((vector ^ mPrev) & mask) != 0);
    if (clear) begin
      mQVec.delete();
      mQTs.delete();
      mOverflow = 1'b0;
      mDrop     = 0;
      mTs       = 0;
      mState    = 0;
    end else begin
      if (pop) begin
        void'(mQVec.pop_front());
        void'(mQTs.pop_front());
      end
      if (evt) begin
        if (mQVec.size() < DEPTH) begin
          mQVec.push_back(vector);
          mQTs.push_back(TSW'(mTs));
        end else begin
          mOverflow = 1'b1;
          if (mDrop < 255) mDrop++;
        end
      end
      case (mState)
        0: if (start && !stop) mState = 1;
        1: begin
          if (stop) mState = 0;
          else if (halt_on_full && mQVec.size() == DEPTH) mState = 2;
        end
        2: if (stop) mState = 0;
        default: mState = 0;
      endcase
      mTs = (mTs + 1) % (1 << TSW);
    end
    mPrev = vector;
  endtask

  task automatic checkOutput(input string where);
    logic [VW-1:0]  expVec;
    logic [TSW-1:0] expTs;
    expVec = (mQVec.size() != 0) ? mQVec[0] : '0;
    expTs  = (mQTs.size() != 0) ? mQTs[0] : '0;
    checkVal({where, ":valid"},    32'(capIf.out_valid),     32'(mQVec.size() != 0));
    checkVal({where, ":vector"},   32'(capIf.out_vector),    32'(expVec));
    checkVal({where, ":ts"},       32'(capIf.out_timestamp), 32'(expTs));
    checkVal({where, ":state"},    32'(state),               32'(mState));
    checkVal({where, ":overflow"}, 32'(overflow),            32'(mOverflow));
    checkVal({where, ":drops"},    32'(drop_count),          32'(mDrop));
    checkVal({where, ":level"},    32'(level),               32'(mQVec.size()));
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, compare after the edge
  task automatic applyStimulus(input logic [VW-1:0] v, input logic [VW-1:0] m,
                               input bit st, input bit sp, input bit cl,
                               input bit hof, input bit rdy, input string where);
    vector          = v;
    mask            = m;
    start           = st;
    stop            = sp;
    clear           = cl;
    halt_on_full    = hof;
    capIf.out_ready = rdy;
    modelStep();
    @(posedge clock);
    @(negedge clock);
    checkOutput(where);
  endtask

  initial begin
    logic [VW-1:0] v;
    logic [VW-1:0] m;
    bit            hof;
    int            readyBias;

    reset           = 1'b1;
    vector          = '0;
    mask            = '0;
    start           = 1'b0;
    stop            = 1'b0;
    clear           = 1'b0;
    halt_on_full    = 1'b0;
    capIf.out_ready = 1'b0;
    modelReset();
    #1;
    checkOutput("reset");
    @(negedge clock);
    reset = 1'b0;

    // Single change at timestamp 10
    applyStimulus(8'h00, 8'hFF, 1, 0, 0, 0, 0, "start");
    while (mTs != 10) applyStimulus(8'h00, 8'hFF, 0, 0, 0, 0, 0, "idle_to_10");
    applyStimulus(8'h05, 8'hFF, 0, 0, 0, 0, 0, "change_ts10");
    checkVal("first_valid",  32'(capIf.out_valid),     32'd1);
    checkVal("first_vector", 32'(capIf.out_vector),    32'h05);
    checkVal("first_ts",     32'(capIf.out_timestamp), 32'd10);
    applyStimulus(8'h05, 8'hFF, 0, 0, 0, 0, 1, "drain_first");

    // Masked-off bits must not trigger
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 8'h0F, 0, 0, 0, 0, 1, "mask_prep");
    applyStimulus(8'hF0, 8'h0F, 0, 0, 0, 0, 0, "masked_change");
    checkVal("masked_valid", 32'(capIf.out_valid), 32'd0);
    checkVal("masked_level", 32'(level),           32'd0);
    applyStimulus(8'hF1, 8'h0F, 0, 0, 0, 0, 0, "unmasked_change");
    checkVal("unmasked_vector", 32'(capIf.out_vector), 32'hF1);
    checkVal("unmasked_level",  32'(level),            32'd1);
    applyStimulus(8'hF1, 8'h0F, 0, 0, 0, 0, 1, "drain_masked");

    // Overflow in drop mode
    applyStimulus(8'hF1, 8'hFF, 0, 0, 1, 0, 0, "clear_drop");
    applyStimulus(8'hF1, 8'hFF, 1, 0, 0, 0, 0, "start_drop");
    for (int i = 1; i <= 10; i++) applyStimulus(VW'(i), 8'hFF, 0, 0, 0, 0, 0, "fill_drop");
    checkVal("drop_level",    32'(level),      32'd8);
    checkVal("drop_overflow", 32'(overflow),   32'd1);
    checkVal("drop_count",    32'(drop_count), 32'd2);
    for (int i = 1; i <= 8; i++) begin
      checkVal("drop_order", 32'(capIf.out_vector), 32'(i));
      applyStimulus(8'd10, 8'hFF, 0, 0, 0, 0, 1, "drain_drop");
    end

    // Overflow in halt mode
    applyStimulus(8'd10, 8'hFF, 0, 0, 1, 1, 0, "clear_halt");
    applyStimulus(8'd10, 8'hFF, 1, 0, 0, 1, 0, "start_halt");
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(VW'(i), 8'hFF, 0, 0, 0, 1, 0, "fill_halt");
      if (i == 8) checkVal("halt_state_at_8", 32'(state), 32'd2);
    end
    checkVal("halt_drops", 32'(drop_count), 32'd0);
    checkVal("halt_level", 32'(level),      32'd8);
    for (int i = 1; i <= 8; i++) begin
      checkVal("halt_order", 32'(capIf.out_vector), 32'(i));
      applyStimulus(8'd10, 8'hFF, 0, 0, 0, 1, 1, "drain_halt");
    end
    applyStimulus(8'd10, 8'hFF, 0, 1, 0, 1, 0, "stop_halt");
    checkVal("halt_stop_state", 32'(state), 32'd0);

    // Push coincident with pop on a full FIFO
    applyStimulus(8'd10, 8'hFF, 0, 0, 1, 0, 0, "clear_pp");
    applyStimulus(8'd10, 8'hFF, 1, 0, 0, 0, 0, "start_pp");
    for (int i = 1; i <= 8; i++) applyStimulus(VW'(i), 8'hFF, 0, 0, 0, 0, 0, "fill_pp");
    applyStimulus(8'h55, 8'hFF, 0, 0, 0, 0, 1, "push_pop_full");
    checkVal("pp_level", 32'(level),      32'd8);
    checkVal("pp_drops", 32'(drop_count), 32'd0);
    for (int i = 2; i <= 8; i++) begin
      checkVal("pp_order", 32'(capIf.out_vector), 32'(i));
      applyStimulus(8'h55, 8'hFF, 0, 0, 0, 0, 1, "drain_pp");
    end
    checkVal("pp_tail", 32'(capIf.out_vector), 32'h55);
    applyStimulus(8'h55, 8'hFF, 0, 0, 0, 0, 1, "drain_pp_tail");

    // Timestamp wrap with a 4-bit counter
    applyStimulus(8'h55, 8'hFF, 0, 0, 1, 0, 1, "clear_wrap");
    applyStimulus(8'h55, 8'hFF, 1, 0, 0, 0, 1, "start_wrap");
    while (mTs != 15) applyStimulus(8'h55, 8'hFF, 0, 0, 0, 0, 1, "idle_to_15");
    applyStimulus(8'hA0, 8'hFF, 0, 0, 0, 0, 1, "change_ts15");
    checkVal("wrap_ts15", 32'(capIf.out_timestamp), 32'd15);
    applyStimulus(8'hA1, 8'hFF, 0, 0, 0, 0, 1, "change_ts0");
    checkVal("wrap_ts0", 32'(capIf.out_timestamp), 32'd0);
    checkVal("wrap_vec", 32'(capIf.out_vector),    32'hA1);

    // Asynchronous reset while entries are queued
    applyStimulus(8'hA2, 8'hFF, 0, 0, 0, 0, 0, "prefill_reset");
    applyStimulus(8'hA3, 8'hFF, 0, 0, 0, 0, 0, "prefill_reset");
    #2;
    reset = 1'b1;
    #1;
    checkVal("async_valid", 32'(capIf.out_valid), 32'd0);
    checkVal("async_level", 32'(level),           32'd0);
    checkVal("async_state", 32'(state),           32'd0);
    modelReset();
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(8'h3C, 8'hFF, 0, 0, 0, 0, 0, "post_reset_no_start");
    checkVal("post_reset_valid", 32'(capIf.out_valid), 32'd0);
    applyStimulus(8'h3C, 8'hFF, 1, 0, 0, 0, 0, "post_reset_start");
    applyStimulus(8'h3D, 8'hFF, 0, 0, 0, 0, 0, "post_reset_change");
    checkVal("post_reset_event", 32'(capIf.out_vector), 32'h3D);

    // Random run against the model
    v         = 8'h3D;
    hof       = 1'b0;
    readyBias = 2;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        hof       = bit'($urandom_range(0, 1));
        readyBias = $urandom_range(0, 3);
      end
      if ($urandom_range(0, 2) != 0) v = v ^ VW'($urandom);
      m = ($urandom_range(0, 3) == 0) ? VW'($urandom) : 8'hFF;
      applyStimulus(v, m,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 59) == 0,
                    hof,
                    $urandom_range(0, 3) < readyBias,
                    "random");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
